// File: rtl/temp_scan_ctrl.sv
// Round-robin scheduler sharing one temp_analyzer across NUM_CH sensor channels,
// with per-channel debounce, worst-case state and a sticky fault interrupt.
module temp_scan_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int SCAN_PERIOD = 1000,
    parameter int DEBOUNCE    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [8*NUM_CH-1:0]   ch_temp,
    output logic [7:0]            ana_temp_data,
    input  logic [1:0]            ana_temp_state,
    output logic [2*NUM_CH-1:0]   ch_state,
    output logic [1:0]            max_state,
    output logic                  scan_done,
    output logic                  fault_irq,
    input  logic                  irq_clr
);
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW = $clog2(SCAN_PERIOD);
    localparam logic [1:0] ST_FAULT = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DRIVE, S_CAPTURE, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [PW-1:0]   period_q, period_d;
    logic [7:0]      data_q, data_d;
    logic            irq_q, irq_d;
    logic [1:0]      st_q   [NUM_CH];
    logic [1:0]      st_d   [NUM_CH];
    logic [1:0]      cand_q [NUM_CH];
    logic [1:0]      cand_d [NUM_CH];
    logic [3:0]      cnt_q  [NUM_CH];
    logic [3:0]      cnt_d  [NUM_CH];
    logic [7:0]      temp_arr [NUM_CH];

    logic            last_ch;
    logic            period_end;
    logic            fault_commit;
    logic [1:0]      s, com, cd;
    logic [3:0]      ct_inc;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign temp_arr[k]          = ch_temp[8*k +: 8];
        assign ch_state[2*k +: 2]   = st_q[k];
    end

    assign last_ch    = (idx_q == IW'(NUM_CH - 1));
    assign period_end = (period_q == PW'(SCAN_PERIOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // DONE can go straight to DRIVE when the period is exactly one scan long.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (enable) state_d = S_DRIVE;
            S_DRIVE:   state_d = S_CAPTURE;
            S_CAPTURE: state_d = last_ch ? S_DONE : S_DRIVE;
            S_DONE: begin
                if (!enable)         state_d = S_IDLE;
                else if (period_end) state_d = S_DRIVE;
                else                 state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!enable)         state_d = S_IDLE;
                else if (period_end) state_d = S_DRIVE;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        scan_done = (state_q == S_DONE);
        max_state = 2'b00;
        for (int k = 0; k < NUM_CH; k++) begin
            if (st_q[k] > max_state) max_state = st_q[k];
        end
    end

    always_comb begin
        idx_d = idx_q;
        if (state_q == S_CAPTURE) idx_d = last_ch ? '0 : idx_q + 1'b1;

        if (state_d == S_IDLE || (state_d == S_DRIVE && state_q != S_CAPTURE))
            period_d = '0;
        else
            period_d = period_end ? '0 : period_q + 1'b1;

        data_d = data_q;
        if (state_d == S_DRIVE) data_d = temp_arr[idx_d];
    end

    always_comb begin
        s      = ana_temp_state;
        com    = st_q[idx_q];
        cd     = cand_q[idx_q];
        ct_inc = cnt_q[idx_q] + 4'd1;
        fault_commit = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            st_d[k]   = st_q[k];
            cand_d[k] = cand_q[k];
            cnt_d[k]  = cnt_q[k];
        end
        if (state_q == S_CAPTURE) begin
            if (s == ST_FAULT && com != ST_FAULT) begin
                st_d[idx_q]  = ST_FAULT;
                cnt_d[idx_q] = 4'd0;
                fault_commit = 1'b1;
            end else if (s == com) begin
                cnt_d[idx_q]  = 4'd0;
                cand_d[idx_q] = s;
            end else if (s == cd) begin
                if (ct_inc == 4'(DEBOUNCE)) begin
                    st_d[idx_q]  = s;
                    cnt_d[idx_q] = 4'd0;
                end else begin
                    cnt_d[idx_q] = ct_inc;
                end
            end else begin
                cand_d[idx_q] = s;
                if (DEBOUNCE == 1) begin
                    st_d[idx_q]  = s;
                    cnt_d[idx_q] = 4'd0;
                end else begin
                    cnt_d[idx_q] = 4'd1;
                end
            end
        end
        // A new FAULT commit wins over a simultaneous clear.
        irq_d = fault_commit ? 1'b1 : (irq_clr ? 1'b0 : irq_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= '0;
            period_q <= '0;
            data_q   <= '0;
            irq_q    <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                st_q[k]   <= 2'b00;
                cand_q[k] <= 2'b00;
                cnt_q[k]  <= 4'd0;
            end
        end else begin
            idx_q    <= idx_d;
            period_q <= period_d;
            data_q   <= data_d;
            irq_q    <= irq_d;
            for (int k = 0; k < NUM_CH; k++) begin
                st_q[k]   <= st_d[k];
                cand_q[k] <= cand_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
        end
    end

    assign ana_temp_data = data_q;
    assign fault_irq     = irq_q;
endmodule

// File: tb/tb_temp_scan_ctrl.sv
// Scoreboard bench for temp_scan_ctrl with a behavioural analyzer:
// <20 IDLE, <50 NORMAL, <100 WARNING, otherwise FAULT.
module tb_temp_scan_ctrl;
    localparam int N  = 4;
    localparam int P  = 20;
    localparam int DB = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        irq_clr;
    logic [31:0] ch_temp;
    logic [7:0]  ana_temp_data;
    logic [1:0]  ana_temp_state;
    logic [7:0]  ch_state;
    logic [1:0]  max_state;
    logic        scan_done;
    logic        fault_irq;

    always #5 clk = ~clk;

    temp_scan_ctrl #(.NUM_CH(N), .SCAN_PERIOD(P), .DEBOUNCE(DB)) dut (
        .clk(clk), .rst(rst), .enable(enable), .ch_temp(ch_temp),
        .ana_temp_data(ana_temp_data), .ana_temp_state(ana_temp_state),
        .ch_state(ch_state), .max_state(max_state), .scan_done(scan_done),
        .fault_irq(fault_irq), .irq_clr(irq_clr)
    );

    function automatic logic [1:0] classify(input logic signed [7:0] t);
        if (t < 20)       return 2'b00;
        else if (t < 50)  return 2'b01;
        else if (t < 100) return 2'b10;
        else              return 2'b11;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) ana_temp_state <= 2'b00;
        else     ana_temp_state <= classify(ana_temp_data);
    end

    typedef struct {
        logic [7:0]  st;
        logic [1:0]  mx;
        logic        irq;
        logic [31:0] dat;
        bit          from_mark;
        int          gap;
    } exp_t;

    exp_t sbq[$];
    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int en_mark = 0;
    logic [7:0] hist [0:8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        int   gap;
        int   last_done;
        for (int i = 8; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = ana_temp_data;
        if (!rst && scan_done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_scan_done", 32'd1, 32'd0);
            end else begin
                e   = sbq.pop_front();
                gap = cyc - (e.from_mark ? en_mark : last_done);
                chk("ch_state", {24'd0, ch_state}, {24'd0, e.st});
                chk("max_state", {30'd0, max_state}, {30'd0, e.mx});
                chk("fault_irq", {31'd0, fault_irq}, {31'd0, e.irq});
                chk("scan_gap", gap, e.gap);
                for (int k = 0; k < N; k++)
                    chk("ana_data", {24'd0, hist[8-2*k]}, {24'd0, e.dat[8*k +: 8]});
            end
            last_done = cyc;
        end
    end

    function automatic logic [31:0] pk(input logic [7:0] c3, c2, c1, c0);
        return {c3, c2, c1, c0};
    endfunction

    task automatic push(input logic [7:0] st, input logic [1:0] mx, input logic irq,
                        input logic [31:0] dat, input bit fm, input int gap);
        exp_t e;
        e.st = st; e.mx = mx; e.irq = irq; e.dat = dat; e.from_mark = fm; e.gap = gap;
        sbq.push_back(e);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (scan_done) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_scan(input logic [31:0] temps, input logic [7:0] st,
                           input logic [1:0] mx, input logic irq);
        ch_temp = temps;
        push(st, mx, irq, temps, 1'b0, P);
        wait_done();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; irq_clr = 1'b0; ch_temp = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", {24'd0, ana_temp_data}, 32'd0);
        chk("rst_ch_state", {24'd0, ch_state}, 32'd0);
        chk("rst_max", {30'd0, max_state}, 32'd0);
        chk("rst_done", {31'd0, scan_done}, 32'd0);
        chk("rst_irq", {31'd0, fault_irq}, 32'd0);
        rst = 1'b0;

        // all-zero scans; first DONE 9 cycles after enable, then every P
        push(8'h00, 2'b00, 1'b0, 32'd0, 1'b1, 9);
        @(posedge clk); #1;
        en_mark = cyc; enable = 1'b1;
        wait_done();
        do_scan(32'd0, 8'h00, 2'b00, 1'b0);

        // ch1 NORMAL commits on the third identical sample
        do_scan(pk(8'd5, 8'd10, 8'd30, 8'hF9), 8'h00, 2'b00, 1'b0);
        do_scan(pk(8'd5, 8'd10, 8'd30, 8'hF9), 8'h00, 2'b00, 1'b0);
        do_scan(pk(8'd5, 8'd10, 8'd30, 8'hF9), 8'h04, 2'b01, 1'b0);

        // ch2 FAULT commits immediately
        do_scan(pk(8'd5, 8'd120, 8'd30, 8'hF9), 8'h34, 2'b11, 1'b1);
        @(posedge clk); #1 irq_clr = 1'b1;
        @(posedge clk); #1 irq_clr = 1'b0;
        chk("irq_clear", {31'd0, fault_irq}, 32'd0);
        do_scan(pk(8'd5, 8'd120, 8'd30, 8'hF9), 8'h34, 2'b11, 1'b0);

        // ch0 chatter never settles
        do_scan(pk(8'd5, 8'd120, 8'd30, 8'd60), 8'h34, 2'b11, 1'b0);
        do_scan(pk(8'd5, 8'd120, 8'd30, 8'd30), 8'h34, 2'b11, 1'b0);
        do_scan(pk(8'd5, 8'd120, 8'd30, 8'd60), 8'h34, 2'b11, 1'b0);

        // enable dropped during ch1 DRIVE: scan still completes, then stops
        ch_temp = pk(8'd70, 8'd120, 8'd30, 8'd30);
        push(8'h34, 2'b11, 1'b0, ch_temp, 1'b0, P);
        repeat (14) @(posedge clk);
        #1 enable = 1'b0;
        wait_done();
        ch_temp = pk(8'd99, 8'd99, 8'd99, 8'd99);
        repeat (50) @(posedge clk);
        #1;
        chk("no_rescan_data", {24'd0, ana_temp_data}, 32'd70);

        // reset in the middle of a scan
        ch_temp = pk(8'd4, 8'd3, 8'd2, 8'd1);
        en_mark = cyc; enable = 1'b1;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1; enable = 1'b0;
        #1;
        chk("mid_rst_data", {24'd0, ana_temp_data}, 32'd0);
        chk("mid_rst_ch_state", {24'd0, ch_state}, 32'd0);
        chk("mid_rst_max", {30'd0, max_state}, 32'd0);
        chk("mid_rst_done", {31'd0, scan_done}, 32'd0);
        chk("mid_rst_irq", {31'd0, fault_irq}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // FAULT commit and irq_clr on the same edge: set wins
        ch_temp = pk(8'd0, 8'd120, 8'd0, 8'd0);
        push(8'h30, 2'b11, 1'b1, ch_temp, 1'b1, 9);
        @(posedge clk); #1;
        en_mark = cyc; enable = 1'b1;
        repeat (6) @(posedge clk);
        #1 irq_clr = 1'b1;
        @(posedge clk); #1 irq_clr = 1'b0;
        wait_done();
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("irq_hold", {31'd0, fault_irq}, 32'd1);

        repeat (30) @(posedge clk);
        #1;
        chk("queue_drained", sbq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/temp_scan_ctrl.md
# temp_scan_ctrl

Round-robin scan scheduler that time-shares one `temp_analyzer` instance between `NUM_CH` temperature sensor channels. It presents each channel's sample to the analyzer and captures the registered 2-bit state. Each channel's state is debounced before it is committed, and the controller reports per-channel and worst-case state plus a sticky fault interrupt. It sits between the sensor input registers and the alarm/reporting logic.

## Interface
- `NUM_CH`, 4: number of sensor channels, 1..16
- `SCAN_PERIOD`, 1000: clock cycles between scan starts; must be ≥ 2*NUM_CH+1
- `DEBOUNCE`, 3: consecutive identical non-FAULT samples required to commit a state change, 1..15
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `enable`  in  1  scan enable, level
- `ch_temp`  in  8*NUM_CH  packed signed samples; channel k at bits [8k+7:8k]
- `ana_temp_data`  out  8  signed sample driven to the shared analyzer, registered
- `ana_temp_state`  in  2  analyzer output: IDLE=00, NORMAL=01, WARNING=10, FAULT=11; valid one clock after `ana_temp_data` changes
- `ch_state`  out  2*NUM_CH  committed state per channel, packed like `ch_temp`
- `max_state`  out  2  numerically largest committed `ch_state`, combinational from committed registers
- `scan_done`  out  1  one-cycle pulse after the last channel of a scan is captured
- `fault_irq`  out  1  sticky; set on any commit into FAULT
- `irq_clr`  in  1  clears `fault_irq`

## Operation
- FSM states: IDLE, WAIT, DRIVE, CAPTURE, DONE.
- IDLE: the period counter is held at 0. If `enable`=1, go to DRIVE with channel index 0.
- DRIVE (1 cycle): `ana_temp_data` <= `ch_temp[idx]` on entry. Go to CAPTURE.
- CAPTURE (1 cycle): sample `ana_temp_state` and update the debounce for `idx`.
  - If `idx`=NUM_CH-1, go to DONE.
  - Otherwise increment `idx` and go to DRIVE.
- DONE (1 cycle): `scan_done`=1.
  - If `enable`=0, go to IDLE.
  - Otherwise go to WAIT.
- WAIT: wait until the period counter reaches SCAN_PERIOD-1, then go to DRIVE with `idx`=0.
  - If `enable` is deasserted during WAIT, go to IDLE on the next edge.
- Period counter: counts from the cycle the scan's first DRIVE is entered and wraps at SCAN_PERIOD. Scan starts are therefore exactly SCAN_PERIOD cycles apart while `enable` is held.
- Mid-scan `enable` deassert does not abort the scan. The current scan completes, including DONE, and the FSM then returns to IDLE.
- Per-channel debounce registers: `cand` (2 bits) and `cnt` (4 bits). At CAPTURE with sample `s`:
  - `s`=FAULT and committed≠FAULT: commit FAULT immediately, `cnt`<=0, set `fault_irq`.
  - `s`=committed: `cnt`<=0, `cand`<=`s`.
  - `s`=`cand`≠committed: `cnt`<=`cnt`+1. If `cnt`+1=DEBOUNCE, commit `s` and set `cnt`<=0.
  - Otherwise: `cand`<=`s`, `cnt`<=1. If DEBOUNCE=1, commit immediately.
  - Leaving FAULT is debounced like any other change.
- `fault_irq`: set-dominant. If a FAULT commit and `irq_clr` occur in the same cycle, `fault_irq` stays 1. `irq_clr` with no FAULT commit clears it on the next edge.
- Reset values:
  - FSM=IDLE, `idx`=0, counter=0.
  - `ana_temp_data`=0, every `ch_state`=IDLE, `cand`=IDLE, `cnt`=0.
  - `max_state`=00, `scan_done`=0, `fault_irq`=0.
- Reset asserted mid-scan returns all of the above to reset values immediately. The scan in progress is lost, with no `scan_done` pulse.

## Timing
- Per channel: 2 cycles, DRIVE then CAPTURE. A scan occupies 2*NUM_CH+1 cycles, including DONE.
- First DRIVE: entered on the first edge where `enable`=1 is sampled in IDLE.
- `ch_state[k]` and `max_state`: update on the edge ending channel k's CAPTURE.
- `fault_irq`: rises on that same edge.
- `scan_done`: high in the cycle after the last CAPTURE.
- `ch_temp`: sampled only in the DRIVE entry cycle. Changes at other times have no effect on the current scan.

## Test plan
- Reset, then `enable`=1 with NUM_CH=4, SCAN_PERIOD=20, all channels = 0 → `ana_temp_data` sequence 0,0,0,0 on 2-cycle spacing. `scan_done` pulses at cycle 9 and cycle 29 after enable. All `ch_state`=00.
- ch1 = 30 for 2 scans, then 3 scans → `ch_state[1]` stays 00 after scans 1–2 and becomes 01 after scan 3. `max_state`=01.
- ch2 = 120 → `ch_state[2]`=11 after the first scan and `fault_irq`=1. `irq_clr` pulsed while 120 persists → `fault_irq` clears, because committed is already FAULT and no new commit occurs.
- Set-vs-clear: ch2 = 120 on a fresh run, with `irq_clr`=1 in the capture cycle → `fault_irq`=1.
- Chatter: ch0 alternating 60, 30, 60 per scan with DEBOUNCE=3 → `ch_state[0]` remains 00.
- `enable` dropped during ch1 DRIVE → ch2 and ch3 are still captured and `scan_done` pulses once, then no further DRIVE. `rst` pulsed mid-scan → all outputs return to reset values within the same cycle.
